// File: rtl/mux_scan_n_if.sv
// mux_scan_n bus: control, packed channel data and registered results.
// The master drives selection/data, the slave returns the selected word.
interface mux_scan_n_if #(
  parameter int N_CH    = 8,
  parameter int W       = 1,
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
);
  logic                en;
  logic                mode;
  logic [SEL_W-1:0]    s;
  logic [N_CH*W-1:0]   i;
  logic [DWELL_W-1:0]  dwell;
  logic [W-1:0]        y;
  logic                y_valid;
  logic [SEL_W-1:0]    ch;
  logic                wrap;
  logic                err;

  modport master (
    output en, mode, s, i, dwell,
    input  y, y_valid, ch, wrap, err
  );

  modport slave (
    input  en, mode, s, i, dwell,
    output y, y_valid, ch, wrap, err
  );
endinterface

// File: rtl/mux_scan_n.sv
// Registered N-channel multiplexer with manual select and
// round-robin auto-scan holding each channel for dwell+1 cycles.
module mux_scan_n #(
  parameter int N_CH    = 8,
  parameter int W       = 1,
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_scan_n_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    MAN,
    SCAN,
    PAUSE
  } state_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);

  state_t             state;
  logic [SEL_W-1:0]   ptr;
  logic [DWELL_W-1:0] cnt;

  logic [W-1:0]       chans [N_CH];
  logic               fresh;
  logic [SEL_W-1:0]   cur;
  logic [DWELL_W-1:0] cur_cnt;
  logic               s_ok;
  logic               adv;
  logic               at_last;
  logic [W-1:0]       man_d;
  logic [W-1:0]       scan_d;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign chans[k] = bus.i[k*W +: W];
  end

  // Scan position for this cycle: restart at 0 unless resuming a scan.
  always_comb begin
    fresh   = (state != SCAN) && (state != PAUSE);
    cur     = fresh ? '0 : ptr;
    cur_cnt = fresh ? '0 : cnt;
    s_ok    = bus.s <= LAST;
    adv     = cur_cnt >= bus.dwell;
    at_last = cur == LAST;
    man_d   = s_ok ? chans[bus.s] : '0;
    scan_d  = chans[cur];
  end

  // Mode FSM, scan pointer/dwell counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      bus.y       <= '0;
      bus.y_valid <= 1'b0;
      bus.ch      <= '0;
      bus.wrap    <= 1'b0;
      bus.err     <= 1'b0;
    end else if (!bus.en) begin
      bus.y_valid <= 1'b0;
      bus.wrap    <= 1'b0;
      bus.err     <= 1'b0;
      unique case (state)
        SCAN:    state <= PAUSE;
        MAN:     state <= IDLE;
        default: state <= state;
      endcase
    end else if (!bus.mode) begin
      state       <= MAN;
      bus.y       <= man_d;
      bus.ch      <= bus.s;
      bus.y_valid <= s_ok;
      bus.err     <= !s_ok;
      bus.wrap    <= 1'b0;
    end else begin
      state       <= SCAN;
      bus.y       <= scan_d;
      bus.ch      <= cur;
      bus.y_valid <= 1'b1;
      bus.err     <= 1'b0;
      if (adv) begin
        cnt      <= '0;
        ptr      <= at_last ? '0 : cur + SEL_W'(1);
        bus.wrap <= at_last;
      end else begin
        cnt      <= cur_cnt + DWELL_W'(1);
        ptr      <= cur;
        bus.wrap <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: directed plan steps plus random traffic
// against a cycle-level reference model, in two configurations.
module tb_mux_scan_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  mux_scan_n_if #(.N_CH(8), .W(1), .SEL_W(3), .DWELL_W(8)) bus_a ();
  mux_scan_n_if #(.N_CH(5), .W(4), .SEL_W(3), .DWELL_W(8)) bus_b ();

  mux_scan_n #(.N_CH(8), .W(1), .SEL_W(3), .DWELL_W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_a),
    .bus   (bus_a)
  );

  mux_scan_n #(.N_CH(5), .W(4), .SEL_W(3), .DWELL_W(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_b),
    .bus   (bus_b)
  );

  int errors = 0;
  int checks = 0;
  string phase = "init";

  int n_of [2] = '{8, 5};
  int w_of [2] = '{1, 4};

  logic [31:0] m_y   [2];
  logic [31:0] m_ch  [2];
  bit          m_v   [2];
  bit          m_wr  [2];
  bit          m_er  [2];
  bit          m_live[2];
  int          m_ptr [2];
  int          m_cnt [2];

  // Reference: one clock edge of the block, from the rules directly.
  task automatic model(input int id, input bit rn, input bit en,
                       input bit mode, input int s,
                       input logic [63:0] iv, input int dw);
    int n;
    int w;
    logic [63:0] mask;
    n = n_of[id];
    w = w_of[id];
    mask = (64'd1 << w) - 64'd1;
    if (!rn) begin
      m_y[id] = 0; m_ch[id] = 0; m_v[id] = 0;
      m_wr[id] = 0; m_er[id] = 0; m_live[id] = 0;
      m_ptr[id] = 0; m_cnt[id] = 0;
    end else if (!en) begin
      m_v[id] = 0; m_wr[id] = 0; m_er[id] = 0;
    end else if (!mode) begin
      m_live[id] = 0;
      m_wr[id] = 0;
      m_ch[id] = 32'(s);
      if (s < n) begin
        m_y[id] = 32'((iv >> (s * w)) & mask);
        m_v[id] = 1; m_er[id] = 0;
      end else begin
        m_y[id] = 0; m_v[id] = 0; m_er[id] = 1;
      end
    end else begin
      if (!m_live[id]) begin
        m_ptr[id] = 0; m_cnt[id] = 0; m_live[id] = 1;
      end
      m_y[id] = 32'((iv >> (m_ptr[id] * w)) & mask);
      m_ch[id] = 32'(m_ptr[id]);
      m_v[id] = 1; m_er[id] = 0;
      if (m_cnt[id] >= dw) begin
        m_cnt[id] = 0;
        m_wr[id] = (m_ptr[id] == n - 1);
        m_ptr[id] = (m_ptr[id] + 1) % n;
      end else begin
        m_cnt[id] = m_cnt[id] + 1;
        m_wr[id] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s/%s got=%0h exp=%0h", phase, tag, got, exp);
    end
  endtask

  task automatic check_a();
    chk("a_y", 32'(bus_a.y), m_y[0]);
    chk("a_valid", 32'(bus_a.y_valid), 32'(m_v[0]));
    chk("a_ch", 32'(bus_a.ch), m_ch[0]);
    chk("a_wrap", 32'(bus_a.wrap), 32'(m_wr[0]));
    chk("a_err", 32'(bus_a.err), 32'(m_er[0]));
    chk("a_excl", 32'(bus_a.wrap & bus_a.err), 32'd0);
  endtask

  task automatic check_b();
    chk("b_y", 32'(bus_b.y), m_y[1]);
    chk("b_valid", 32'(bus_b.y_valid), 32'(m_v[1]));
    chk("b_ch", 32'(bus_b.ch), m_ch[1]);
    chk("b_wrap", 32'(bus_b.wrap), 32'(m_wr[1]));
    chk("b_err", 32'(bus_b.err), 32'(m_er[1]));
    chk("b_excl", 32'(bus_b.wrap & bus_b.err), 32'd0);
  endtask

  task automatic step_a(input bit rn, input bit en, input bit mode,
                        input int s, input logic [7:0] iv,
                        input int dw);
    rst_a = rn;
    bus_a.en = en;
    bus_a.mode = mode;
    bus_a.s = 3'(s);
    bus_a.i = iv;
    bus_a.dwell = 8'(dw);
    @(posedge clk);
    model(0, rn, en, mode, s, 64'(iv), dw);
    #1;
    check_a();
  endtask

  task automatic step_b(input bit rn, input bit en, input bit mode,
                        input int s, input logic [19:0] iv,
                        input int dw);
    rst_b = rn;
    bus_b.en = en;
    bus_b.mode = mode;
    bus_b.s = 3'(s);
    bus_b.i = iv;
    bus_b.dwell = 8'(dw);
    @(posedge clk);
    model(1, rn, en, mode, s, 64'(iv), dw);
    #1;
    check_b();
  endtask

  logic [7:0] man_i [8] = '{8'b00000001, 8'b00000101, 8'b00100001,
                            8'b00001001, 8'b10000001, 8'b01100001,
                            8'b11000001, 8'b00000111};
  logic       man_y [8] = '{1'b1, 1'b0, 1'b0, 1'b1,
                            1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int wraps;
    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.en = 0; bus_a.mode = 0; bus_a.s = '0;
    bus_a.i = '0; bus_a.dwell = '0;
    bus_b.en = 0; bus_b.mode = 0; bus_b.s = '0;
    bus_b.i = '0; bus_b.dwell = '0;

    phase = "reset";
    step_a(0, 1, 1, 5, 8'hFF, 0);
    step_a(0, 0, 0, 0, 8'hFF, 0);
    chk("rst_y", 32'(bus_a.y), 32'd0);
    chk("rst_ch", 32'(bus_a.ch), 32'd0);

    phase = "idle";
    step_a(1, 0, 0, 0, 8'hFF, 0);

    phase = "manual";
    for (int k = 0; k < 8; k++) begin
      step_a(1, 1, 0, k, man_i[k], 0);
      chk("plan_y", 32'(bus_a.y), 32'(man_y[k]));
      chk("plan_ch", 32'(bus_a.ch), 32'(k));
    end

    phase = "scan";
    step_a(1, 0, 0, 0, 8'hA5, 2);
    wraps = 0;
    for (int c = 0; c < 25; c++) begin
      step_a(1, 1, 1, 0, 8'hA5, 2);
      if (bus_a.wrap) wraps++;
      chk("plan_ch", 32'(bus_a.ch), 32'((c / 3) % 8));
    end
    chk("wrap_count", 32'(wraps), 32'd1);

    phase = "pause";
    step_a(1, 1, 0, 0, 8'hA5, 0);
    for (int c = 0; c < 20; c++) begin
      step_a(1, 1, 1, 0, 8'hA5, 0);
      if (m_ch[0] == 3) break;
    end
    for (int c = 0; c < 5; c++) begin
      step_a(1, 0, 1, 0, 8'hA5, 0);
      chk("hold_ch", 32'(bus_a.ch), 32'd3);
      chk("hold_valid", 32'(bus_a.y_valid), 32'd0);
    end
    step_a(1, 1, 1, 0, 8'hA5, 0);
    chk("resume_ch", 32'(bus_a.ch), 32'd4);
    step_a(1, 1, 0, 0, 8'hA5, 0);
    step_a(1, 1, 1, 0, 8'hA5, 0);
    chk("restart_ch", 32'(bus_a.ch), 32'd0);

    phase = "dwell";
    step_a(1, 1, 0, 0, 8'h3C, 0);
    for (int c = 0; c < 5; c++) step_a(1, 1, 1, 0, 8'h3C, 10);
    step_a(1, 1, 1, 0, 8'h3C, 1);
    chk("lower_ch", 32'(bus_a.ch), 32'd0);
    step_a(1, 1, 1, 0, 8'h3C, 1);
    chk("next_ch0", 32'(bus_a.ch), 32'd1);
    step_a(1, 1, 1, 0, 8'h3C, 1);
    chk("next_ch1", 32'(bus_a.ch), 32'd1);
    step_a(1, 1, 1, 0, 8'h3C, 1);
    chk("next_ch2", 32'(bus_a.ch), 32'd2);

    phase = "rstmid";
    step_a(1, 1, 0, 0, 8'hC3, 0);
    for (int c = 0; c < 20; c++) begin
      step_a(1, 1, 1, 0, 8'hC3, 0);
      if (m_ch[0] == 6 && m_v[0]) break;
    end
    step_a(0, 1, 1, 0, 8'hC3, 0);
    chk("rst_ch", 32'(bus_a.ch), 32'd0);
    chk("rst_valid", 32'(bus_a.y_valid), 32'd0);
    step_a(1, 1, 1, 0, 8'hC3, 0);
    chk("re_ch", 32'(bus_a.ch), 32'd0);
    chk("re_valid", 32'(bus_a.y_valid), 32'd1);

    phase = "rand_a";
    for (int c = 0; c < 400; c++) begin
      step_a($urandom_range(0, 40) != 0, $urandom_range(0, 5) != 0,
             1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             8'($urandom), int'($urandom_range(0, 3)));
    end

    rst_a = 1'b0;

    phase = "range";
    step_b(0, 0, 0, 0, 20'h0, 0);
    step_b(1, 1, 0, 6, 20'hFFFFF, 0);
    chk("oor_err", 32'(bus_b.err), 32'd1);
    chk("oor_y", 32'(bus_b.y), 32'd0);
    chk("oor_valid", 32'(bus_b.y_valid), 32'd0);
    step_b(1, 1, 0, 4, 20'hC1234, 0);
    chk("s4_y", 32'(bus_b.y), 32'hC);
    chk("s4_err", 32'(bus_b.err), 32'd0);
    step_b(1, 1, 1, 0, 20'h5A3F1, 0);
    for (int c = 0; c < 6; c++) step_b(1, 1, 1, 0, 20'h5A3F1, 0);

    phase = "rand_b";
    for (int c = 0; c < 300; c++) begin
      step_b($urandom_range(0, 40) != 0, $urandom_range(0, 5) != 0,
             1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             20'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
